mj_key_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the microprocessor board top's mode state machine. It turns the raw, bouncing, active-low `enter_bar` pushbutton and the raw slide switches into clean synchronous signals. The outputs are a debounced enter level, a single-cycle enter pulse, a single-cycle long-press pulse, and a switch snapshot captured at the moment of the press. The mode FSM consumes `enter_pulse` and `sw_snap` instead of the raw pins.

---
 rtl/mj_key_conditioner.sv | 161 ++++++++++++++++
 tb/tb_mj_key_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mj_key_conditioner.sv
// mj_key_conditioner
//
// Cleans up the raw inputs that feed the board's mode state machine. The
// bouncing active-low enter pushbutton becomes a debounced level, a one-cycle
// press strobe and a one-cycle long-press strobe. The slide switches are
// synchronized, and a snapshot of them is taken at the moment of each
// accepted press.
//
// Ports:
//   clk_50M      in   system clock
//   rst          in   synchronous, active-high reset
//   enter_bar    in   raw pushbutton, asynchronous, active low
//   sw           in   raw slide switches, asynchronous
//   sw_sync      out  sw after a 2-FF synchronizer
//   sw_snap      out  sw_sync captured on each accepted press
//   enter        out  debounced key level, 1 = pressed
//   enter_pulse  out  one-cycle strobe on each accepted press
//   hold_pulse   out  one-cycle strobe once a press has lasted HOLD_CYCLES
//
// Handshake: there is none. Every output is a plain level or a one-cycle
// strobe, valid in the cycle it is high, with no backpressure from the
// consumer.
//
// The FSM state is held in state_q; enter is decoded directly from it.

module mj_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int SW_WIDTH        = 10
) (
    input  logic                clk_50M,
    input  logic                rst,
    input  logic                enter_bar,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [SW_WIDTH-1:0] sw_sync,
    output logic [SW_WIDTH-1:0] sw_snap,
    output logic                enter,
    output logic                enter_pulse,
    output logic                hold_pulse
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // One extra code above HOLD_CYCLES-1 is the saturated "already fired" value.
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_SAT  = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic enter_pulse_q, enter_pulse_d;
    logic hold_pulse_q, hold_pulse_d;
    logic [SW_WIDTH-1:0] sw_snap_q, sw_snap_d;

    // Synchronizers. The key chain carries the inverted pin, so a cleared
    // chain reads "released".
    logic key_meta_q, key_s_q;
    logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;

    // State register: synchronizers, FSM state, counters and registered strobes.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            key_meta_q    <= 1'b0;
            key_s_q       <= 1'b0;
            sw_meta_q     <= '0;
            sw_sync_q     <= '0;
            state_q       <= ST_IDLE;
            dcnt_q        <= '0;
            hcnt_q        <= '0;
            enter_pulse_q <= 1'b0;
            hold_pulse_q  <= 1'b0;
            sw_snap_q     <= '0;
        end else begin
            key_meta_q    <= ~enter_bar;
            key_s_q       <= key_meta_q;
            sw_meta_q     <= sw;
            sw_sync_q     <= sw_meta_q;
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            hcnt_q        <= hcnt_d;
            enter_pulse_q <= enter_pulse_d;
            hold_pulse_q  <= hold_pulse_d;
            sw_snap_q     <= sw_snap_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d       = state_q;
        dcnt_d        = dcnt_q;
        hcnt_d        = hcnt_q;
        enter_pulse_d = 1'b0;
        hold_pulse_d  = 1'b0;
        sw_snap_d     = sw_snap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_s_q) begin
                    state_d = ST_PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!key_s_q) begin
                    state_d = ST_IDLE;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d       = ST_PRESSED;
                    enter_pulse_d = 1'b1;
                    sw_snap_d     = sw_sync_q;
                    hcnt_d        = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                // Release is tested first so it wins over a coincident hold.
                if (!key_s_q) begin
                    state_d = ST_RELEASE_WAIT;
                    dcnt_d  = '0;
                end else if (hcnt_q == HCNT_LAST) begin
                    hold_pulse_d = 1'b1;
                    hcnt_d       = HCNT_SAT;
                end else if (hcnt_q != HCNT_SAT) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            ST_RELEASE_WAIT: begin
                // A short release glitch returns to PRESSED with hcnt frozen,
                // so the hold timer resumes rather than restarting.
                if (key_s_q) begin
                    state_d = ST_PRESSED;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        enter       = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
        enter_pulse = enter_pulse_q;
        hold_pulse  = hold_pulse_q;
        sw_snap     = sw_snap_q;
        sw_sync     = sw_sync_q;
    end

endmodule

// File: tb/tb_mj_key_conditioner.sv
// Testbench for mj_key_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
//
// A table of steps drives rst/enter_bar/sw for a number of cycles and checks
// the level outputs at the end of each step. Steps that begin a qualifying
// press push the expected enter_pulse cycle and snapshot (and, where the press
// lasts long enough, the expected hold_pulse cycle) onto scoreboard queues; a
// negedge monitor pops and compares whenever a strobe appears and flags any
// strobe that is missing, extra or repeated.
//
// Cycle bookkeeping: cyc counts posedges. Inputs driven at a negedge where
// cyc == c0 are first sampled by the edge that makes cyc == c0+1 ("edge 0"),
// so a press is seen at the negedge with cyc == c0 + D + 3.

module tb_mj_key_conditioner;

    localparam int D  = 4;
    localparam int H  = 20;
    localparam int W  = 10;
    localparam int PRESS_LAT = D + 3;

    logic         clk_50M = 1'b0;
    logic         rst = 1'b1;
    logic         enter_bar = 1'b1;
    logic [W-1:0] sw = '0;
    logic [W-1:0] sw_sync;
    logic [W-1:0] sw_snap;
    logic         enter;
    logic         enter_pulse;
    logic         hold_pulse;

    mj_key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .SW_WIDTH       (W)
    ) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .enter_bar  (enter_bar),
        .sw         (sw),
        .sw_sync    (sw_sync),
        .sw_snap    (sw_snap),
        .enter      (enter),
        .enter_pulse(enter_pulse),
        .hold_pulse (hold_pulse)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [41:0] exp_q[$];   // {expected cycle, expected sw_snap}
    logic [31:0] hold_q[$];  // expected hold_pulse cycle

    task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    logic prev_ep = 1'b0;
    logic prev_hp = 1'b0;
    logic [41:0] mon_e;
    logic [31:0] mon_h;

    always @(negedge clk_50M) begin
        if (enter_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_enter_pulse", 42'(enter_pulse), 42'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("enter_pulse_cycle", 42'(cyc), 42'(mon_e[41:10]));
                chk("enter_pulse_snap", 42'(sw_snap), 42'(mon_e[9:0]));
            end
            chk("enter_pulse_single", 42'(prev_ep), 42'(0));
        end else if (exp_q.size() > 0 && int'(exp_q[0][41:10]) < cyc) begin
            mon_e = exp_q.pop_front();
            chk("missed_enter_pulse", 42'(enter_pulse), 42'(1));
        end

        if (hold_pulse === 1'b1) begin
            if (hold_q.size() == 0) begin
                chk("unexpected_hold_pulse", 42'(hold_pulse), 42'(0));
            end else begin
                mon_h = hold_q.pop_front();
                chk("hold_pulse_cycle", 42'(cyc), 42'(mon_h));
            end
            chk("hold_pulse_single", 42'(prev_hp), 42'(0));
        end else if (hold_q.size() > 0 && int'(hold_q[0]) < cyc) begin
            mon_h = hold_q.pop_front();
            chk("missed_hold_pulse", 42'(hold_pulse), 42'(1));
        end

        prev_ep <= (enter_pulse === 1'b1);
        prev_hp <= (hold_pulse === 1'b1);
    end

    // ---------------- stimulus table ----------------
    typedef struct {
        logic         rst;
        logic         bar;
        logic [W-1:0] sw;
        int           len;
        bit           press;     // expect an enter_pulse PRESS_LAT after step start
        int           hold_at;   // expected hold_pulse offset from step start, 0 = none
        logic         exp_enter;
        logic [W-1:0] exp_snap;
        logic [W-1:0] exp_sync;
    } step_t;

    step_t steps[$];

    function automatic void add(input logic r, input logic b, input logic [W-1:0] s,
                                input int len, input bit press, input int hold_at,
                                input logic e_enter, input logic [W-1:0] e_snap,
                                input logic [W-1:0] e_sync);
        steps.push_back('{r, b, s, len, press, hold_at, e_enter, e_snap, e_sync});
    endfunction

    // Watchdog: every step is bounded, this only guards against a stalled clock.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with key held, then a press re-qualified after reset.
        add(1, 0, 10'h3FF,  3, 0,  0, 0, 10'h000, 10'h000);
        add(0, 0, 10'h3FF, 10, 1,  0, 1, 10'h3FF, 10'h3FF);
        // Reset mid-press, key still held: back to idle, then one new press.
        add(1, 0, 10'h3FF,  3, 0,  0, 0, 10'h000, 10'h000);
        add(0, 0, 10'h3FF, 10, 1,  0, 1, 10'h3FF, 10'h3FF);
        add(0, 1, 10'h3FF,  7, 0,  0, 0, 10'h3FF, 10'h3FF);
        add(1, 1, 10'h000,  2, 0,  0, 0, 10'h000, 10'h000);
        // 3: bounce on press, 3 low / 2 high never reaches D+1 stable samples.
        for (int k = 0; k < 10; k++) begin
            add(0, 0, 10'h3C3, 3, 0, 0, 0, 10'h000, 10'h3C3);
            add(0, 1, 10'h3C3, 2, 0, 0, 0, 10'h000, 10'h3C3);
        end
        add(0, 1, 10'h3C3,  8, 0,  0, 0, 10'h000, 10'h3C3);
        // 2: long press; pulse at +7, hold at +27, enter still 1 six cycles
        // after release and 0 on the seventh.
        add(0, 0, 10'h2A5, 40, 1, 27, 1, 10'h2A5, 10'h2A5);
        add(0, 1, 10'h2A5,  6, 0,  0, 1, 10'h2A5, 10'h2A5);
        add(0, 1, 10'h2A5,  1, 0,  0, 0, 10'h2A5, 10'h2A5);
        add(0, 1, 10'h2A5,  8, 0,  0, 0, 10'h2A5, 10'h2A5);
        // 4: 2-cycle release glitch. key_s is low for two edges; the hold
        // counter misses the edge into RELEASE_WAIT, the one edge spent there
        // and the edge back to PRESSED, so hold moves from +27 to +30.
        add(0, 0, 10'h011, 12, 1, 30, 1, 10'h011, 10'h011);
        add(0, 1, 10'h011,  2, 0,  0, 1, 10'h011, 10'h011);
        add(0, 0, 10'h011, 30, 0,  0, 1, 10'h011, 10'h011);
        add(0, 1, 10'h011,  7, 0,  0, 0, 10'h011, 10'h011);
        add(0, 1, 10'h011,  6, 0,  0, 0, 10'h011, 10'h011);
        // 5: snapshot stays while sw changes; sw_sync follows after 2 cycles.
        add(0, 0, 10'h0F0, 10, 1, 27, 1, 10'h0F0, 10'h0F0);
        add(0, 0, 10'h155,  1, 0,  0, 1, 10'h0F0, 10'h0F0);
        add(0, 0, 10'h155,  1, 0,  0, 1, 10'h0F0, 10'h155);
        add(0, 0, 10'h155, 20, 0,  0, 1, 10'h0F0, 10'h155);
        add(0, 1, 10'h155,  7, 0,  0, 0, 10'h0F0, 10'h155);
        add(0, 1, 10'h155,  6, 0,  0, 0, 10'h0F0, 10'h155);
        add(0, 0, 10'h155, 10, 1,  0, 1, 10'h155, 10'h155);
        add(0, 1, 10'h155,  7, 0,  0, 0, 10'h155, 10'h155);
        add(0, 1, 10'h155,  6, 0,  0, 0, 10'h155, 10'h155);
        // 6: 24 low cycles puts the falling key_s on the edge where hcnt==19:
        // no hold. One cycle longer and the hold fires at +27.
        add(0, 0, 10'h0C3, 24, 1,  0, 1, 10'h0C3, 10'h0C3);
        add(0, 1, 10'h0C3,  6, 0,  0, 1, 10'h0C3, 10'h0C3);
        add(0, 1, 10'h0C3,  1, 0,  0, 0, 10'h0C3, 10'h0C3);
        add(0, 1, 10'h0C3,  6, 0,  0, 0, 10'h0C3, 10'h0C3);
        add(0, 0, 10'h301, 25, 1, 27, 1, 10'h301, 10'h301);
        add(0, 1, 10'h301,  6, 0,  0, 1, 10'h301, 10'h301);
        add(0, 1, 10'h301,  1, 0,  0, 0, 10'h301, 10'h301);
        add(0, 1, 10'h301,  6, 0,  0, 0, 10'h301, 10'h301);

        @(negedge clk_50M);
        for (int i = 0; i < steps.size(); i++) begin
            rst       = steps[i].rst;
            enter_bar = steps[i].bar;
            sw        = steps[i].sw;
            if (steps[i].press)
                exp_q.push_back({32'(cyc + PRESS_LAT), steps[i].sw});
            if (steps[i].hold_at > 0)
                hold_q.push_back(32'(cyc + steps[i].hold_at));
            repeat (steps[i].len) @(negedge clk_50M);
            chk($sformatf("step%0d_enter", i), 42'(enter), 42'(steps[i].exp_enter));
            chk($sformatf("step%0d_sw_snap", i), 42'(sw_snap), 42'(steps[i].exp_snap));
            chk($sformatf("step%0d_sw_sync", i), 42'(sw_sync), 42'(steps[i].exp_sync));
        end

        repeat (10) @(negedge clk_50M);
        chk("enter_pulse_left_pending", 42'(exp_q.size()), 42'(0));
        chk("hold_pulse_left_pending", 42'(hold_q.size()), 42'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
